mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM pipeline stage; consumes the EX/MEM register outputs and produces the values latched by the MEM/WB register.
- Issues load/store requests to the data-memory port using a ready handshake, and handles byte-lane selection, store-data replication and load sign/zero extension.
- Raises a stall request while a memory access is outstanding, and holds completed load data if the pipeline is frozen.

Parameters:
- ADDR_WIDTH, 32, width of memory address and PC.
- REG_ADDR_WIDTH, 5, width of register-file write address.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- stall_current_stage  in  1  pipeline controller freezes the MEM stage.
- mem_read_flag_in  in  1  load instruction.
- mem_write_flag_in  in  1  store instruction.
- mem_sign_flag_in  in  1  1 = sign-extend load, 0 = zero-extend load.
- mem_sel_in  in  4  access size: 0001 byte, 0011 half, 1111 word.
- mem_write_data_in  in  32  store data, right-aligned.
- result_in  in  32  ALU result; this is the effective address for memory ops.
- reg_write_en_in  in  1  register write enable.
- reg_write_addr_in  in  REG_ADDR_WIDTH  destination register.
- current_pc_addr_in  in  ADDR_WIDTH  PC of the instruction.
- hi_write_data_in  in  32  HI data.
- lo_write_data_in  in  32  LO data.
- hilo_write_en_in  in  1  HI/LO write enable.
- ram_en  out  1  memory request valid.
- ram_write_en  out  4  byte-lane write strobes.
- ram_addr  out  ADDR_WIDTH  word-aligned address.
- ram_write_data  out  32  lane-replicated store data.
- ram_read_data  in  32  read data; valid when ram_ready is high.
- ram_ready  in  1  access complete this cycle.
- stall_request  out  1  MEM stage needs more cycles.
- misalign_flag  out  1  illegal or misaligned access detected.
- result_out  out  32  load value or pass-through result_in.
- reg_write_en_out  out  1  to MEM/WB.
- reg_write_addr_out  out  REG_ADDR_WIDTH  pass-through.
- current_pc_addr_out  out  ADDR_WIDTH  pass-through.
- hi_write_data_out, lo_write_data_out  out  32 each  pass-through.
- hilo_write_en_out  out  1  pass-through.

Behaviour:
- Reset: while rst is high, all outputs are 0 and the FSM is in IDLE. Reset asserted mid-access drops ram_en immediately; the memory must tolerate an abandoned request.
- Access decode:
  - access = (read xor write) and legal and aligned.
  - legal: mem_sel_in is one of 0001, 0011, 1111.
  - aligned: half requires addr[0]=0; word requires addr[1:0]=00.
  - Read and write both high, an illegal sel, or misalignment -> misalign_flag=1, no bus request, reg_write_en_out=0.
  - No memory op (neither flag set) -> no request, misalign_flag=0.
- Bus signals (little-endian):
  - ram_addr = {result_in[ADDR_WIDTH-1:2], 2'b00}.
  - Lane mask = mem_sel_in << addr[1:0].
  - ram_write_en = lane mask on stores, 0000 on loads.
  - ram_write_data: byte = {4{d[7:0]}}, half = {2{d[15:0]}}, word = d.
- Load extraction: select the byte/half at addr[1:0] from the data source (see FSM), then sign- or zero-extend to 32 bits per mem_sign_flag_in.
- FSM states:
  - IDLE:
    - ram_en = access.
    - access & ram_ready: complete with zero wait and no stall; go to HOLD if stall_current_stage is high, else stay in IDLE.
    - access & !ram_ready: go to WAIT.
  - WAIT:
    - ram_en=1; address, strobes and data held stable from the inputs.
    - On ram_ready: complete; go to HOLD if stall_current_stage is high, else IDLE.
  - HOLD:
    - ram_en=0, so the access is never re-issued.
    - result_out comes from the captured load register.
    - Go to IDLE when stall_current_stage is low.
- On completion, ram_read_data is captured into the load register.
- Data source for result_out: HOLD uses the captured register; otherwise ram_read_data. Non-load instructions pass result_in.
- stall_request = ram_en & ~ram_ready (combinational). It is 0 in HOLD.
- reg_write_en_out = reg_write_en_in & ~misalign_flag & ~stall_request.
- ram_ready sampled in IDLE with no access, or in HOLD, is ignored.
- Remaining outputs pass straight through.

Test Plan:
- Word load, addr 0x100, ram_ready high same cycle, read data 0xDEADBEEF -> stall_request never high; result_out=0xDEADBEEF; FSM stays in IDLE.
- Signed byte load at 0x103, data 0x80FF_FF12, ready after 3 cycles -> stall_request high for 3 cycles; ram_en held for 4 cycles; result_out=0xFFFFFF80. Zero-extend variant gives 0x00000080.
- Half store at 0x102 with data 0x0000ABCD -> ram_write_en=1100; ram_write_data=0xABCDABCD; ram_addr=0x100.
- Load completes while stall_current_stage is held high for 2 cycles with ram_read_data changing -> FSM in HOLD; ram_en=0; result_out keeps the captured value; returns to IDLE after the release.
- Word load at 0x102, and a read+write simultaneously -> misalign_flag=1; ram_en=0; reg_write_en_out=0.
- rst asserted during WAIT -> all outputs 0 with no clock edge; after release, the FSM is in IDLE and the next access proceeds normally.

Source files
------------

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues load/store requests on a ready-handshake data
// port, steers byte lanes, replicates store data, and sign/zero-extends
// loads. It requests a stall while an access is outstanding and holds the
// completed load value while the pipeline is frozen.
module mem_access_stage #(
  parameter int ADDR_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      stall_current_stage,
  input  logic                      mem_read_flag_in,
  input  logic                      mem_write_flag_in,
  input  logic                      mem_sign_flag_in,
  input  logic [3:0]                mem_sel_in,
  input  logic [31:0]               mem_write_data_in,
  input  logic [31:0]               result_in,
  input  logic                      reg_write_en_in,
  input  logic [REG_ADDR_WIDTH-1:0] reg_write_addr_in,
  input  logic [ADDR_WIDTH-1:0]     current_pc_addr_in,
  input  logic [31:0]               hi_write_data_in,
  input  logic [31:0]               lo_write_data_in,
  input  logic                      hilo_write_en_in,
  output logic                      ram_en,
  output logic [3:0]                ram_write_en,
  output logic [ADDR_WIDTH-1:0]     ram_addr,
  output logic [31:0]               ram_write_data,
  input  logic [31:0]               ram_read_data,
  input  logic                      ram_ready,
  output logic                      stall_request,
  output logic                      misalign_flag,
  output logic [31:0]               result_out,
  output logic                      reg_write_en_out,
  output logic [REG_ADDR_WIDTH-1:0] reg_write_addr_out,
  output logic [ADDR_WIDTH-1:0]     current_pc_addr_out,
  output logic [31:0]               hi_write_data_out,
  output logic [31:0]               lo_write_data_out,
  output logic                      hilo_write_en_out
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] load_q, load_d;

  logic        mem_op, legal, aligned, access, misalign;
  logic        en_c, stall_c, complete;
  logic [1:0]  off;
  logic [3:0]  lane_mask;
  logic [31:0] wdata_c, src, shifted, load_val;

  // Access decode, bus request and handshake
  always_comb begin
    off      = result_in[1:0];
    mem_op   = mem_read_flag_in | mem_write_flag_in;
    legal    = (mem_sel_in == 4'b0001) || (mem_sel_in == 4'b0011) ||
               (mem_sel_in == 4'b1111);
    aligned  = (mem_sel_in == 4'b0001) ||
               ((mem_sel_in == 4'b0011) && !off[0]) ||
               ((mem_sel_in == 4'b1111) && (off == 2'b00));
    access   = (mem_read_flag_in ^ mem_write_flag_in) & legal & aligned;
    misalign = mem_op & ~access;

    // WAIT keeps the request up unconditionally; HOLD never re-issues it.
    en_c     = ((state_q == IDLE) & access) | (state_q == WAIT);
    stall_c  = en_c & ~ram_ready;
    complete = en_c & ram_ready;

    lane_mask = mem_sel_in << off;
    case (mem_sel_in)
      4'b0001: wdata_c = {4{mem_write_data_in[7:0]}};
      4'b0011: wdata_c = {2{mem_write_data_in[15:0]}};
      default: wdata_c = mem_write_data_in;
    endcase
  end

  // Load lane extraction and extension
  always_comb begin
    src     = (state_q == HOLD) ? load_q : ram_read_data;
    shifted = src >> {off, 3'b000};
    case (mem_sel_in)
      4'b0001: load_val = {{24{mem_sign_flag_in & shifted[7]}}, shifted[7:0]};
      4'b0011: load_val = {{16{mem_sign_flag_in & shifted[15]}}, shifted[15:0]};
      default: load_val = src;
    endcase
  end

  // Next-state and load-capture logic
  always_comb begin
    state_d = state_q;
    load_d  = load_q;
    if (complete) load_d = ram_read_data;
    case (state_q)
      IDLE: if (access) begin
              if (!ram_ready)               state_d = WAIT;
              else if (stall_current_stage) state_d = HOLD;
            end
      WAIT: if (ram_ready) state_d = stall_current_stage ? HOLD : IDLE;
      HOLD: if (!stall_current_stage) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and captured-load registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      load_q  <= '0;
    end else begin
      state_q <= state_d;
      load_q  <= load_d;
    end
  end

  // Output drive; everything is forced low while reset is asserted so an
  // in-flight request is dropped without waiting for a clock edge.
  always_comb begin
    ram_en              = 1'b0;
    ram_write_en        = '0;
    ram_addr            = '0;
    ram_write_data      = '0;
    stall_request       = 1'b0;
    misalign_flag       = 1'b0;
    result_out          = '0;
    reg_write_en_out    = 1'b0;
    reg_write_addr_out  = '0;
    current_pc_addr_out = '0;
    hi_write_data_out   = '0;
    lo_write_data_out   = '0;
    hilo_write_en_out   = 1'b0;
    if (!rst) begin
      ram_en              = en_c;
      ram_write_en        = (en_c & mem_write_flag_in) ? lane_mask : 4'b0000;
      ram_addr            = {result_in[ADDR_WIDTH-1:2], 2'b00};
      ram_write_data      = wdata_c;
      stall_request       = stall_c;
      misalign_flag       = misalign;
      result_out          = mem_read_flag_in ? load_val : result_in;
      reg_write_en_out    = reg_write_en_in & ~misalign & ~stall_c;
      reg_write_addr_out  = reg_write_addr_in;
      current_pc_addr_out = current_pc_addr_in;
      hi_write_data_out   = hi_write_data_in;
      lo_write_data_out   = lo_write_data_in;
      hilo_write_en_out   = hilo_write_en_in;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed-vector bench for mem_access_stage.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_current_stage;
  logic        mem_read_flag_in, mem_write_flag_in, mem_sign_flag_in;
  logic [3:0]  mem_sel_in;
  logic [31:0] mem_write_data_in, result_in;
  logic        reg_write_en_in;
  logic [4:0]  reg_write_addr_in;
  logic [31:0] current_pc_addr_in, hi_write_data_in, lo_write_data_in;
  logic        hilo_write_en_in;
  logic        ram_en;
  logic [3:0]  ram_write_en;
  logic [31:0] ram_addr, ram_write_data, ram_read_data;
  logic        ram_ready;
  logic        stall_request, misalign_flag;
  logic [31:0] result_out;
  logic        reg_write_en_out;
  logic [4:0]  reg_write_addr_out;
  logic [31:0] current_pc_addr_out, hi_write_data_out, lo_write_data_out;
  logic        hilo_write_en_out;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.ADDR_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .stall_current_stage(stall_current_stage),
    .mem_read_flag_in(mem_read_flag_in), .mem_write_flag_in(mem_write_flag_in),
    .mem_sign_flag_in(mem_sign_flag_in), .mem_sel_in(mem_sel_in),
    .mem_write_data_in(mem_write_data_in), .result_in(result_in),
    .reg_write_en_in(reg_write_en_in), .reg_write_addr_in(reg_write_addr_in),
    .current_pc_addr_in(current_pc_addr_in), .hi_write_data_in(hi_write_data_in),
    .lo_write_data_in(lo_write_data_in), .hilo_write_en_in(hilo_write_en_in),
    .ram_en(ram_en), .ram_write_en(ram_write_en), .ram_addr(ram_addr),
    .ram_write_data(ram_write_data), .ram_read_data(ram_read_data),
    .ram_ready(ram_ready), .stall_request(stall_request),
    .misalign_flag(misalign_flag), .result_out(result_out),
    .reg_write_en_out(reg_write_en_out), .reg_write_addr_out(reg_write_addr_out),
    .current_pc_addr_out(current_pc_addr_out),
    .hi_write_data_out(hi_write_data_out), .lo_write_data_out(lo_write_data_out),
    .hilo_write_en_out(hilo_write_en_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Set up one memory op: rd, wr, sign, sel, address, store data
  task automatic op(input logic rd, input logic wr, input logic sg,
                    input logic [3:0] sel, input logic [31:0] addr,
                    input logic [31:0] wd);
    mem_read_flag_in  = rd;
    mem_write_flag_in = wr;
    mem_sign_flag_in  = sg;
    mem_sel_in        = sel;
    result_in         = addr;
    mem_write_data_in = wd;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    stall_current_stage = 1'b0;
    reg_write_en_in = 1'b1;
    reg_write_addr_in = 5'd7;
    current_pc_addr_in = 32'h0000_1234;
    hi_write_data_in = 32'hAAAA_0001;
    lo_write_data_in = 32'h5555_0002;
    hilo_write_en_in = 1'b1;
    ram_read_data = 32'hDEAD_BEEF;
    ram_ready = 1'b1;
    op(1'b1, 1'b0, 1'b0, 4'b1111, 32'h100, 32'h0);

    // Reset: every output low even with an access presented
    check("rst_ram_en", {31'b0, ram_en}, 32'h0);
    check("rst_result", result_out, 32'h0);
    check("rst_pc", current_pc_addr_out, 32'h0);
    check("rst_wen", {31'b0, reg_write_en_out}, 32'h0);
    tick(); tick();
    rst = 1'b0;
    #1;

    // Zero-wait word load
    check("w0_ram_en", {31'b0, ram_en}, 32'h1);
    check("w0_stall", {31'b0, stall_request}, 32'h0);
    check("w0_result", result_out, 32'hDEAD_BEEF);
    check("w0_addr", ram_addr, 32'h100);
    check("w0_strobe", {28'b0, ram_write_en}, 32'h0);
    check("w0_wen", {31'b0, reg_write_en_out}, 32'h1);
    check("w0_pc", current_pc_addr_out, 32'h1234);
    check("w0_hi", hi_write_data_out, 32'hAAAA_0001);
    check("w0_lo", lo_write_data_out, 32'h5555_0002);
    check("w0_waddr", {27'b0, reg_write_addr_out}, 32'd7);
    tick();
    // Still IDLE: the request is re-issued and stalls when not ready
    ram_ready = 1'b0;
    #1;
    check("w0_idle_en", {31'b0, ram_en}, 32'h1);
    check("w0_idle_stall", {31'b0, stall_request}, 32'h1);
    check("w0_idle_wen", {31'b0, reg_write_en_out}, 32'h0);
    op(1'b0, 1'b0, 1'b0, 4'b1111, 32'h0, 32'h0);
    tick();

    // Signed byte load at 0x103, ready after 3 cycles
    ram_read_data = 32'h80FF_FF12;
    op(1'b1, 1'b0, 1'b1, 4'b0001, 32'h103, 32'h0);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("sb_en%0d", i), {31'b0, ram_en}, 32'h1);
      check($sformatf("sb_stall%0d", i), {31'b0, stall_request}, 32'h1);
      tick();
    end
    ram_ready = 1'b1;
    #1;
    check("sb_en3", {31'b0, ram_en}, 32'h1);
    check("sb_stall3", {31'b0, stall_request}, 32'h0);
    check("sb_result", result_out, 32'hFFFF_FF80);
    check("sb_addr", ram_addr, 32'h100);
    tick();
    // Zero-extend variant, zero wait
    op(1'b1, 1'b0, 1'b0, 4'b0001, 32'h103, 32'h0);
    check("zb_result", result_out, 32'h0000_0080);
    tick();

    // Half store at 0x102
    op(1'b0, 1'b1, 1'b0, 4'b0011, 32'h102, 32'h0000_ABCD);
    check("hs_strobe", {28'b0, ram_write_en}, 32'hC);
    check("hs_wdata", ram_write_data, 32'hABCD_ABCD);
    check("hs_addr", ram_addr, 32'h100);
    check("hs_en", {31'b0, ram_en}, 32'h1);
    check("hs_misalign", {31'b0, misalign_flag}, 32'h0);
    check("hs_result", result_out, 32'h102);
    tick();
    // Byte store at 0x101
    op(1'b0, 1'b1, 1'b0, 4'b0001, 32'h101, 32'h0000_00A5);
    check("bs_strobe", {28'b0, ram_write_en}, 32'h2);
    check("bs_wdata", ram_write_data, 32'hA5A5_A5A5);
    tick();

    // Load completes while the pipeline is frozen for 2 cycles
    ram_read_data = 32'h1122_3344;
    stall_current_stage = 1'b1;
    op(1'b1, 1'b0, 1'b0, 4'b1111, 32'h200, 32'h0);
    check("hd_first", result_out, 32'h1122_3344);
    tick();
    ram_read_data = 32'h5566_7788;
    #1;
    check("hd_en0", {31'b0, ram_en}, 32'h0);
    check("hd_stall0", {31'b0, stall_request}, 32'h0);
    check("hd_result0", result_out, 32'h1122_3344);
    tick();
    ram_read_data = 32'h99AA_BBCC;
    stall_current_stage = 1'b0;
    ram_ready = 1'b0;
    #1;
    check("hd_en1", {31'b0, ram_en}, 32'h0);
    check("hd_result1", result_out, 32'h1122_3344);
    tick();
    check("hd_idle_en", {31'b0, ram_en}, 32'h1);
    check("hd_idle_stall", {31'b0, stall_request}, 32'h1);
    ram_ready = 1'b1;
    ram_read_data = 32'hCAFE_F00D;
    #1;
    check("hd_idle_result", result_out, 32'hCAFE_F00D);
    tick();

    // Illegal / misaligned accesses
    op(1'b1, 1'b0, 1'b0, 4'b1111, 32'h102, 32'h0);
    check("ma_word_flag", {31'b0, misalign_flag}, 32'h1);
    check("ma_word_en", {31'b0, ram_en}, 32'h0);
    check("ma_word_wen", {31'b0, reg_write_en_out}, 32'h0);
    op(1'b1, 1'b1, 1'b0, 4'b1111, 32'h100, 32'h0);
    check("ma_rw_flag", {31'b0, misalign_flag}, 32'h1);
    check("ma_rw_en", {31'b0, ram_en}, 32'h0);
    check("ma_rw_strobe", {28'b0, ram_write_en}, 32'h0);
    op(1'b1, 1'b0, 1'b0, 4'b0111, 32'h100, 32'h0);
    check("ma_sel_flag", {31'b0, misalign_flag}, 32'h1);
    op(1'b0, 1'b1, 1'b0, 4'b0011, 32'h101, 32'h0);
    check("ma_half_flag", {31'b0, misalign_flag}, 32'h1);
    op(1'b0, 1'b0, 1'b0, 4'b1111, 32'h101, 32'h0);
    check("noop_flag", {31'b0, misalign_flag}, 32'h0);
    check("noop_en", {31'b0, ram_en}, 32'h0);
    check("noop_wen", {31'b0, reg_write_en_out}, 32'h1);
    tick();

    // Reset asserted during WAIT
    ram_ready = 1'b0;
    op(1'b1, 1'b0, 1'b0, 4'b1111, 32'h300, 32'h0);
    tick();
    check("rw_wait_en", {31'b0, ram_en}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check("rw_en", {31'b0, ram_en}, 32'h0);
    check("rw_stall", {31'b0, stall_request}, 32'h0);
    check("rw_addr", ram_addr, 32'h0);
    check("rw_hi", hi_write_data_out, 32'h0);
    op(1'b0, 1'b0, 1'b0, 4'b1111, 32'h0, 32'h0);
    tick();
    rst = 1'b0;
    #1;
    // Back in IDLE: no request without an access
    check("rw_idle_en", {31'b0, ram_en}, 32'h0);
    ram_ready = 1'b1;
    ram_read_data = 32'h8001_0000;
    op(1'b1, 1'b0, 1'b1, 4'b0011, 32'h102, 32'h0);
    check("rw_next_en", {31'b0, ram_en}, 32'h1);
    check("rw_next_result", result_out, 32'hFFFF_8001);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
